// File: rtl/cache_fill_if.sv
// Cache fill bus: the miss/store requests from the I- and D-cache controllers, the
// main-memory access port and the fill return path.
// The slave modport is the fill controller; the master modport is the surrounding
// caches and memory.
interface cache_fill_if;
    // Cache-side requests
    logic        i_miss_req;
    logic [15:0] i_miss_addr;
    logic        d_miss_req;
    logic [15:0] d_miss_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    // Memory port
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_rdata;
    // Fill return and status
    logic        fill_valid;
    logic        fill_dst;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        wr_ack;
    logic        busy;

    modport slave (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data,
        input  mem_data_valid, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_valid, fill_dst, fill_word, fill_data,
        output i_fill_done, d_fill_done, wr_ack, busy
    );

    modport master (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data,
        output mem_data_valid, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_valid, fill_dst, fill_word, fill_data,
        input  i_fill_done, d_fill_done, wr_ack, busy
    );
endinterface

// File: rtl/cache_fill_controller.sv
// Cache fill controller: arbitrates D-cache stores, D-cache misses and I-cache misses
// (in that priority order), issues eight pipelined word reads per 16-byte block and
// returns each word tagged with its offset, pulsing a per-cache done when complete.
// Optional feature macro FILL_CRITICAL_WORD_FIRST_EN: start the block fill at the
// missed word and wrap, instead of always starting at word 0.
module cache_fill_controller #(
    parameter int unsigned MEM_LATENCY     = 4,
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input logic       clk,
    input logic       rst_n,
    cache_fill_if.slave bus
);

    // The datapath is built for 8-word blocks; latency only matters to the memory.
    if (WORDS_PER_BLOCK != 8 || MEM_LATENCY == 0) begin : g_param_check
        $error("cache_fill_controller: unsupported parameter values");
    end

    typedef enum logic [2:0] {StIdle, StWrite, StIssue, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_q;        // 0 = I-cache, 1 = D-cache
    logic [11:0] line_q;         // block address bits [15:4]
    logic [2:0]  base_q;         // first word offset of the current fill
    logic [2:0]  issue_ctr_q;
    logic [2:0]  rx_ctr_q;
    logic        fill_valid_q;
    logic [2:0]  fill_word_q;
    logic [15:0] fill_data_q;

    logic        grant_fill;
    logic        grant_dst;
    logic [15:0] grant_addr;
    logic [2:0]  grant_start;
    logic [2:0]  last_ctr;
    logic        rx_active;
    logic        last_issue;
    logic        last_rx;

    // Arbitration and end-of-block detection
    always_comb begin
        grant_dst  = bus.d_miss_req;
        grant_addr = bus.d_miss_req ? bus.d_miss_addr : bus.i_miss_addr;
        grant_fill = !bus.d_wr_req && (bus.d_miss_req || bus.i_miss_req);
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        grant_start = grant_addr[3:1];
`else
        grant_start = 3'd0;
`endif
        // Both counters wrap, so the eighth word sits one behind the start offset.
        last_ctr   = base_q + 3'd7;
        rx_active  = bus.mem_data_valid && (state_q == StIssue || state_q == StDrain);
        last_issue = (issue_ctr_q == last_ctr);
        last_rx    = rx_active && (rx_ctr_q == last_ctr);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.d_wr_req) begin
                    state_d = StWrite;
                end else if (grant_fill) begin
                    state_d = StIssue;
                end
            end
            StWrite: state_d = StIdle;
            StIssue: if (last_issue) state_d = StDrain;
            StDrain: if (last_rx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant latch, issue/receive counters and registered fill return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            line_q       <= 12'd0;
            base_q       <= 3'd0;
            issue_ctr_q  <= 3'd0;
            rx_ctr_q     <= 3'd0;
            fill_valid_q <= 1'b0;
            fill_word_q  <= 3'd0;
            fill_data_q  <= 16'd0;
        end else begin
            if (state_q == StIdle && grant_fill) begin
                owner_q     <= grant_dst;
                line_q      <= grant_addr[15:4];
                base_q      <= grant_start;
                issue_ctr_q <= grant_start;
                rx_ctr_q    <= grant_start;
            end
            if (state_q == StIssue) begin
                issue_ctr_q <= issue_ctr_q + 3'd1;
            end
            if (rx_active) begin
                rx_ctr_q    <= rx_ctr_q + 3'd1;
                fill_word_q <= rx_ctr_q;
                fill_data_q <= bus.mem_rdata;
            end
            fill_valid_q <= rx_active;
        end
    end

    // Output decode
    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = 16'd0;
        bus.mem_wdata   = 16'd0;
        bus.wr_ack      = 1'b0;
        bus.i_fill_done = 1'b0;
        bus.d_fill_done = 1'b0;
        unique case (state_q)
            StWrite: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_wr_addr;
                bus.mem_wdata = bus.d_wr_data;
                bus.wr_ack    = 1'b1;
            end
            StIssue: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = {line_q, issue_ctr_q, 1'b0};
            end
            StDone: begin
                bus.i_fill_done = !owner_q;
                bus.d_fill_done = owner_q;
            end
            default: ;
        endcase
        bus.busy       = (state_q != StIdle);
        bus.fill_valid = fill_valid_q;
        bus.fill_dst   = owner_q;
        bus.fill_word  = fill_word_q;
        bus.fill_data  = fill_data_q;
    end

endmodule
